// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// States, bytes per word and bytes in the length header.
package loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Latency: word and word_done are valid combinationally with the 4th byte.
// Backpressure: none; shifts only when shift_en is high.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]                    idx;
  logic [8*(WORD_BYTES-1)-1:0]   low_bytes;

  // The incoming byte fills the top lane directly, so only the lower three
  // lanes of the 32-bit shift register need storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      low_bytes <= '0;
    end else if (shift_en) begin
      idx       <= idx + 2'd1;
      low_bytes <= {rx_byte, low_bytes[8*(WORD_BYTES-1)-1:8]};
    end
  end

  assign word      = {rx_byte, low_bytes};
  assign word_done = shift_en && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, LE word packing, imem writes, then cpu_run.
// Latency: write one cycle after a word's 4th byte; optional trailing checksum via IMEM_LOADER_CHECKSUM_EN.
// Backpressure: rx_ready is a registered state decode, low during writes and in terminal states.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_wen,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_err,
  output logic [15:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t S_TAIL = S_CSUM;
`else
  localparam loader_state_t S_TAIL = S_RUN;
`endif

  loader_state_t                state;
  loader_state_t                state_nxt;
  logic [8*(LEN_BYTES-1)-1:0]   len_lo;
  logic [15:0]                  n_words;
  logic [15:0]                  len_rx;
  logic                         rx_fire;
  logic [31:0]                  word;
  logic                         word_done;

  assign rx_fire = rx_valid && rx_ready;
  assign len_rx  = {rx_data, len_lo};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (rx_fire && (state == S_DATA)),
    .rx_byte   (rx_data),
    .word      (word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_fin;

  assign csum_fin = csum + rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'd0;
    end else if (rx_fire) begin
      csum <= csum_fin;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0: begin
        if (rx_fire) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        if (rx_fire) begin
          if ({1'b0, len_rx} > 17'(MAX_WORDS)) state_nxt = S_ERR;
          else if (len_rx == 16'd0)            state_nxt = S_TAIL;
          else                                 state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if ((words_loaded + 16'd1) == n_words) state_nxt = S_TAIL;
        else                                   state_nxt = S_DATA;
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_fire) state_nxt = (csum_fin == 8'd0) ? S_RUN : S_ERR;
`else
        state_nxt = S_ERR;
`endif
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Outputs decode the next state so they are registered yet line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LEN0;
      rx_ready     <= 1'b0;
      imem_wen     <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 16'd0;
      len_lo       <= '0;
      n_words      <= 16'd0;
    end else begin
      state    <= state_nxt;
      rx_ready <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                  (state_nxt == S_DATA) || (state_nxt == S_CSUM);
      imem_wen <= (state_nxt == S_WRITE);
      cpu_run  <= (state_nxt == S_RUN);
      load_err <= (state_nxt == S_ERR);
      if (rx_fire && (state == S_LEN0)) len_lo  <= rx_data;
      if (rx_fire && (state == S_LEN1)) n_words <= len_rx;
      if (word_done) begin
        imem_addr  <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
        imem_wdata <= word;
      end
      if (state == S_WRITE) words_loaded <= words_loaded + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven streams, random streams,
// and hand sequences for mid-load reset and checksum rejection.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FF80;
  localparam int          MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        imem_wen;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_wen     (imem_wen),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observed write log and first cycles of cpu_run / load_err.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  int          run_cyc = -1;
  int          err_cyc = -1;
  logic [31:0] hold_addr = BASE;
  logic [31:0] hold_data = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      hold_addr = BASE;
      hold_data = 32'd0;
    end else begin
      if (imem_wen) begin
        wq.push_back('{imem_addr, imem_wdata, cyc});
        chk("rx_ready_low_during_write", {31'd0, rx_ready}, 32'd0);
        hold_addr = imem_addr;
        hold_data = imem_wdata;
      end else begin
        chk("imem_addr_hold", imem_addr, hold_addr);
        chk("imem_wdata_hold", imem_wdata, hold_data);
      end
      if (cpu_run && run_cyc < 0)  run_cyc = cyc;
      if (load_err && err_cyc < 0) err_cyc = cyc;
    end
  end

  logic [7:0] stream[$];
  int         acc[$];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_imem_wen"}, {31'd0, imem_wen}, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, BASE);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    wq.delete();
    acc.delete();
    run_cyc = -1;
    err_cyc = -1;
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);
  endtask

  // Stream: LEN_LO, LEN_HI, 4*N LE data bytes (only when N fits), checksum if enabled.
  task automatic build(input int n, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    logic [7:0]  sum;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
        for (int b = 0; b < 4; b++) stream.push_back(8'(w >> (8 * b)));
      end
      if (CSUM_EN) begin
        sum = 8'd0;
        foreach (stream[k]) sum = sum + stream[k];
        stream.push_back(8'd0 - sum);
      end
    end
  endtask

  // mode 0: valid always high, 1: valid every other cycle, 2: random valid.
  task automatic drive(input int mode, input int limit);
    int  i = 0;
    int  idle = 0;
    logic v;
    while (i < limit) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
      rx_valid = v;
      rx_data  = v ? stream[i] : 8'($urandom);
      if (v && rx_ready) begin
        acc.push_back(cyc);
        i++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 40) begin
          chk("byte_accept_timeout", i, limit);
          break;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Extra bytes offered after the image must never be taken.
  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n, input logic exp_run,
                           input logic exp_err, input int exp_words);
    int ew;
    int b;
    int last;
    ew = (n > MAXW) ? 0 : n;
    chk({tag, "_write_count"}, wq.size(), ew);
    for (int i = 0; i < ew && i < wq.size(); i++) begin
      b = 2 + 4 * i;
      chk($sformatf("%s_addr%0d", tag, i), wq[i].addr, BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wq[i].data,
          {stream[b+3], stream[b+2], stream[b+1], stream[b]});
      chk($sformatf("%s_wcyc%0d", tag, i), wq[i].cyc, acc[b+3] + 1);
    end
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_run});
    chk({tag, "_load_err"}, {31'd0, load_err}, {31'd0, exp_err});
    chk({tag, "_words_loaded"}, {16'd0, words_loaded}, exp_words);
    chk({tag, "_rx_ready_final"}, {31'd0, rx_ready}, 32'd0);
    last = (acc.size() > 0) ? acc[acc.size()-1] : 0;
    chk({tag, "_run_cycle"}, run_cyc,
        exp_run ? last + ((n > 0 && !CSUM_EN) ? 2 : 1) : -1);
    chk({tag, "_err_cycle"}, err_cyc, exp_err ? last + 1 : -1);
  endtask

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          mode;
    logic        exp_run;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic good;
    tbl[0] = '{2,     32'h0000_0013, 32'h0010_0093, 0, 1'b1, 1'b0, 2};
    tbl[1] = '{2,     32'h0000_0013, 32'h0010_0093, 1, 1'b1, 1'b0, 2};
    tbl[2] = '{2,     32'h0000_0013, 32'h0010_0093, 2, 1'b1, 1'b0, 2};
    tbl[3] = '{0,     32'h0,         32'h0,         0, 1'b1, 1'b0, 0};
    tbl[4] = '{257,   32'h0,         32'h0,         0, 1'b0, 1'b1, 0};
    tbl[5] = '{1,     32'h0000_0013, 32'h0,         2, 1'b1, 1'b0, 1};
    tbl[6] = '{256,   32'hDEAD_BEEF, 32'h0123_4567, 2, 1'b1, 1'b0, 256};
    tbl[7] = '{65535, 32'h0,         32'h0,         1, 1'b0, 1'b1, 0};
    tbl[8] = '{5,     32'hA5A5_5A5A, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 5};

    for (int t = 0; t < 9; t++) begin
      do_reset();
      build(tbl[t].n, tbl[t].w0, tbl[t].w1);
      drive(tbl[t].mode, stream.size());
      drain(8);
      check_run($sformatf("vec%0d", t), tbl[t].n, tbl[t].exp_run,
                tbl[t].exp_err, tbl[t].exp_words);
    end

    // Random lengths around the MAX_WORDS boundary.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, MAXW + 12);
      good = (n <= MAXW);
      do_reset();
      build(n, $urandom, $urandom);
      drive(2, stream.size());
      drain(6);
      check_run($sformatf("rand%0d_n%0d", r, n), n, good, !good, good ? n : 0);
    end

    // Reset after 5 data bytes, then a clean single-word image.
    do_reset();
    build(2, 32'h0000_0013, 32'h0010_0093);
    drive(0, 7);
    repeat (2) @(negedge clk);
    do_reset();
    build(1, 32'h0000_0013, 32'h0);
    drive(0, stream.size());
    drain(6);
    check_run("midreset", 1, 1'b1, 1'b0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum: word still written, load rejected.
    do_reset();
    build(1, 32'h0000_0013, 32'h0);
    chk("csum_good_byte", {24'd0, stream[6]}, 32'h0000_00EC);
    stream[6] = 8'hED;
    drive(0, stream.size());
    drain(6);
    check_run("csum_bad", 1, 1'b0, 1'b1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory programmer sitting directly upstream of the CPU datapath. Accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit little-endian instruction words, and writes them into instruction memory through its write port at consecutive byte addresses. Holds the CPU in its not-running state until the image is complete, then asserts `cpu_run` permanently.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0: byte address of the first word written.
- `MAX_WORDS`, 256: largest accepted image, in words; range 1..65535.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: upstream byte valid.
- `rx_data` in 8: upstream byte.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `imem_wen` out 1: instruction-memory write enable, one-cycle pulse per word.
- `imem_addr` out 32: instruction-memory byte address.
- `imem_wdata` out 32: instruction word to write.
- `cpu_run` out 1: image loaded; CPU may fetch.
- `load_err` out 1: image rejected; sticky until reset.
- `words_loaded` out 16: count of words written so far.

## Operation
- Byte transfer occurs on a rising edge with `rx_valid && rx_ready`. `rx_data` is ignored otherwise.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes, each word least-significant byte first.
- States:
  - `S_LEN0`: reset state.
  - `S_LEN1`
  - `S_DATA`: byte index 0..3.
  - `S_WRITE`
  - `S_CSUM`: only when configured.
  - `S_RUN`
  - `S_ERR`
- `S_LEN0` → `S_LEN1` on a byte. `S_LEN1` → decision on a byte:
  - N > MAX_WORDS → `S_ERR`.
  - N == 0 → `S_CSUM`, or `S_RUN` if unconfigured.
  - Otherwise → `S_DATA`.
- `S_DATA` shifts bytes into the word register. The 4th byte → `S_WRITE`.
- `S_WRITE` (exactly one cycle):
  - `imem_wen`=1, `imem_addr`=BASE_ADDR + 4·words_loaded, `imem_wdata`=assembled word.
  - `words_loaded` increments at the end of the cycle.
  - Next state: `S_DATA` if more words remain, else `S_CSUM`/`S_RUN`.
- Address arithmetic is 32-bit and wraps modulo 2^32. No range check beyond MAX_WORDS.
- `S_RUN` and `S_ERR` are terminal until `rst`. In these states `rx_ready`=0 and further bytes are not accepted.
- Reset mid-load aborts the load immediately. Memory contents already written are left as-is; the next load overwrites them.

## Timing
- Reset values:
  - `rx_ready`=0 during reset; 1 from the first clock edge after reset deasserts.
  - `imem_wen`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `cpu_run`=0, `load_err`=0, `words_loaded`=0.
- `rx_ready`=1 in `S_LEN0`, `S_LEN1`, `S_DATA`, `S_CSUM`; 0 in `S_WRITE`, `S_RUN`, `S_ERR`. `rx_ready` is a registered state decode and does not depend combinationally on `rx_valid`.
- Throughput: at most 4 bytes per 5 cycles while loading data.
- Latency: the write occurs in the cycle after the 4th byte is accepted.
- `cpu_run` rises in the cycle after the final write, or after the checksum byte is accepted, or after LEN_HI when N=0.
- All outputs are registered. `imem_addr` and `imem_wdata` hold their values outside `S_WRITE`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - One trailing byte C follows the data. The 8-bit sum of all bytes (LEN_LO..C) modulo 256 must equal 0.
  - Sum == 0 → `S_RUN`. Otherwise → `S_ERR` with `cpu_run`=0.
  - Words already written remain in memory.
- Undefined: no checksum byte and no `S_CSUM` state. `S_RUN` follows the last write directly. `load_err` is asserted only by the length check.

## Structure
- Shared package `loader_pkg`:
  - State enum `loader_state_t`.
  - Constant `WORD_BYTES`=4.
  - Constant `LEN_BYTES`=2.
- One sub-module is natural: `byte_packer`.
  - Contains the 2-bit byte index, the 32-bit shift register, and a `word_done` strobe.
  - The top block holds the FSM, address/count logic, and checksum accumulator.

## Test plan
- N=2 stream: 02 00 13 00 00 00 93 00 10 00. Expect:
  - Write 0x00000013 @BASE.
  - Write 0x00100093 @BASE+4.
  - `cpu_run`=1 one cycle after the 2nd `imem_wen`.
  - `words_loaded`=2.
- Bytes sent with `rx_valid` toggling every other cycle, plus `rx_valid` held high during `S_WRITE` → identical writes, no byte lost or duplicated.
- LEN=0x0101 with MAX_WORDS=256 → `load_err`=1 after LEN_HI, `cpu_run`=0, `rx_ready`=0 thereafter.
- N=0 stream (00 00, plus checksum 00 if enabled) → no `imem_wen`, `cpu_run`=1.
- `IMEM_LOADER_CHECKSUM_EN`:
  - N=1, word 0x00000013, C=0xEC → `cpu_run`=1.
  - Same stream with C=0xED → `load_err`=1, `cpu_run`=0.
- `rst` pulsed after 5 data bytes, then a full N=1 stream → single write @BASE, all outputs equal reset values during reset.
